// File: rtl/mem_dump_reader_if.sv
// Debug-port and display-path bundle for the memory dump reader.
// master = the reader (initiator); slave = memory controller and display side.
interface mem_dump_reader_if #(
    parameter int ADDR_W = 6
);
    logic              read_mem_en;
    logic [ADDR_W-1:0] read_mem_addr;
    logic [31:0]       read_data;
    logic [31:0]       word_out;
    logic [ADDR_W-1:0] addr_out;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output read_mem_en, read_mem_addr, word_out, addr_out, word_valid,
        input  read_data, word_ready
    );

    modport slave (
        input  read_mem_en, read_mem_addr, word_out, addr_out, word_valid,
        output read_data, word_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Walks data memory 0..LAST_ADDR through the controller debug port once the CPU
// is halted, handing each word to the display with a valid/ready handshake.
module mem_dump_reader #(
    parameter int ADDR_W    = 6,
    parameter int LAST_ADDR = 63,
    parameter int DWELL     = 50_000_000,
    parameter int DWELL_W   = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_auto,
    input  logic              step,
    input  logic              cpu_halted,
    mem_dump_reader_if.master bus,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_HALT = 3'd1,
        S_READ      = 3'd2,
        S_PRESENT   = 3'd3,
        S_DWELL     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST       = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]  r_addr_out, w_addr_out_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [31:0]        r_word, w_word_nxt;
    logic               r_valid, r_busy, r_done;
    logic               w_leave;

    // The debug read is gated by cpu_halted so the port is released the moment the CPU resumes.
    assign bus.read_mem_en   = (r_state == S_READ) && cpu_halted;
    assign bus.read_mem_addr = bus.read_mem_en ? r_addr : ADDR_ZERO;
    assign bus.word_out      = r_word;
    assign bus.addr_out      = r_addr_out;
    assign bus.word_valid    = r_valid;
    assign busy              = r_busy;
    assign done              = r_done;

    // Next-state, scan counter, dwell counter and capture logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_addr_out_nxt = r_addr_out;
        w_dwell_nxt    = r_dwell;
        w_word_nxt     = r_word;
        w_leave        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_addr_nxt  = ADDR_ZERO;
                    w_state_nxt = cpu_halted ? S_READ : S_WAIT_HALT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WAIT_HALT: begin
                if (cpu_halted) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_WAIT_HALT;
                end
            end
            S_READ: begin
                if (cpu_halted) begin
                    w_word_nxt     = bus.read_data;
                    w_addr_out_nxt = r_addr;
                    w_state_nxt    = S_PRESENT;
                end else begin
                    w_state_nxt = S_WAIT_HALT;
                end
            end
            S_PRESENT: begin
                if (bus.word_ready) begin
                    w_dwell_nxt = DWELL_LOAD;
                    w_state_nxt = S_DWELL;
                end else begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_DWELL: begin
                // Manual mode leaves the dwell count untouched so a switch back to auto resumes it.
                if (mode_auto) begin
                    if (r_dwell == DWELL_ZERO) begin
                        w_leave = 1'b1;
                    end else begin
                        w_dwell_nxt = r_dwell - DWELL_ONE;
                    end
                end else begin
                    w_leave = step;
                end
                if (!w_leave) begin
                    w_state_nxt = S_DWELL;
                end else if (r_addr == LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_ONE;
                    w_state_nxt = cpu_halted ? S_READ : S_WAIT_HALT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= ADDR_ZERO;
            r_addr_out <= ADDR_ZERO;
            r_dwell    <= DWELL_ZERO;
            r_word     <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_addr_out <= w_addr_out_nxt;
            r_dwell    <= w_dwell_nxt;
            r_word     <= w_word_nxt;
            r_valid    <= (w_state_nxt == S_PRESENT);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomised and directed bench for mem_dump_reader, checked every cycle against
// a timeline model of the scan (pending read, word on display, dwell, done).
module tb_mem_dump_reader;
    localparam int ADDR_W = 3;
    localparam int LAST   = 3;
    localparam int DWELL  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, mode_auto = 1'b0, step = 1'b0, cpu_halted = 1'b0, ready = 1'b0;
    logic busy, done;
    logic [31:0] mem [0:7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_dump_reader_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.read_data  = mem[bus.read_mem_addr];
    assign bus.word_ready = ready;

    mem_dump_reader #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST), .DWELL(DWELL), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_auto(mode_auto), .step(step),
        .cpu_halted(cpu_halted), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a scan is a chain of per-address episodes: read pending -> on display -> dwelling.
    bit          m_active = 1'b0, m_done = 1'b0, m_req = 1'b0, m_vis = 1'b0, m_hold = 1'b0;
    bit          m_prev_halt = 1'b0;
    int          m_idx = 0, m_addr = 0, m_hold_left = 0;
    logic [31:0] m_word = 32'h0;
    int          acc_addr[$];
    logic [31:0] acc_word[$];
    int          en_cnt = 0, t_start = -1, t_en = -1, t_valid = -1, t_done = -1;

    initial begin
        logic exp_en;
        logic [ADDR_W-1:0] exp_addr;
        bit leave;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_en",    64'(bus.read_mem_en),   64'(1'b0));
                chk("rst_raddr", 64'(bus.read_mem_addr), 64'(3'd0));
                chk("rst_valid", 64'(bus.word_valid),    64'(1'b0));
                chk("rst_word",  64'(bus.word_out),      64'(32'd0));
                chk("rst_aout",  64'(bus.addr_out),      64'(3'd0));
                chk("rst_busy",  64'(busy),              64'(1'b0));
                chk("rst_done",  64'(done),              64'(1'b0));
                m_active = 1'b0; m_done = 1'b0; m_req = 1'b0; m_vis = 1'b0; m_hold = 1'b0;
                m_idx = 0; m_addr = 0; m_word = 32'h0;
            end else begin
                // A read happens only after two consecutive halted cycles while one is pending.
                exp_en   = m_req && cpu_halted && m_prev_halt;
                exp_addr = exp_en ? ADDR_W'(m_idx) : 3'd0;
                chk("read_en",    64'(bus.read_mem_en),   64'(exp_en));
                chk("read_addr",  64'(bus.read_mem_addr), 64'(exp_addr));
                chk("word_valid", 64'(bus.word_valid),    64'(m_vis));
                chk("busy",       64'(busy),              64'(m_active));
                chk("done",       64'(done),              64'(m_done));
                chk("word_out",   64'(bus.word_out),      64'(m_word));
                chk("addr_out",   64'(bus.addr_out),      64'(m_addr));
                if (bus.read_mem_en) en_cnt++;
                if (bus.read_mem_en && t_en < 0) t_en = cyc;
                if (bus.word_valid && t_valid < 0) t_valid = cyc;
                if (done && t_done < 0) t_done = cyc;
                if (bus.word_valid && ready) begin
                    acc_addr.push_back(int'(bus.addr_out));
                    acc_word.push_back(bus.word_out);
                end
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1; m_done = 1'b0; m_idx = 0; m_req = 1'b1; t_start = cyc;
                    end
                end else if (m_req) begin
                    if (exp_en) begin
                        m_req = 1'b0; m_vis = 1'b1; m_word = mem[m_idx]; m_addr = m_idx;
                    end
                end else if (m_vis) begin
                    if (ready) begin
                        m_vis = 1'b0; m_hold = 1'b1; m_hold_left = DWELL;
                    end
                end else if (m_hold) begin
                    leave = mode_auto ? (m_hold_left == 1) : step;
                    if (mode_auto && !leave) m_hold_left--;
                    if (leave) begin
                        m_hold = 1'b0;
                        if (m_idx == LAST) begin
                            m_active = 1'b0; m_done = 1'b1;
                        end else begin
                            m_idx++; m_req = 1'b1;
                        end
                    end
                end
            end
            m_prev_halt = cpu_halted;
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc_wait(1); start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc_wait(1); step = 1'b0;
    endtask

    task automatic clear_acc();
        acc_addr.delete();
        acc_word.delete();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done", 64'(done), 64'(1'b1));
        cyc_wait(1);
    endtask

    task automatic chk_full_scan(input string name);
        chk({name, "_count"}, 64'(acc_addr.size()), 64'(LAST + 1));
        for (int i = 0; i < acc_addr.size() && i <= LAST; i++) begin
            chk({name, "_addr"}, 64'(acc_addr[i]), 64'(i));
            chk({name, "_word"}, 64'(acc_word[i]), 64'(mem[i]));
        end
    endtask

    initial begin
        int d;
        bit found;
        for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + 32'(i);
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(2);

        // 1: auto mode, always ready; pins latency and total scan length.
        mode_auto = 1'b1; cpu_halted = 1'b1; ready = 1'b1;
        clear_acc(); t_en = -1; t_valid = -1; t_done = -1;
        pulse_start();
        wait_done(60);
        chk("t1_en_lat",    64'(t_en - t_start),    64'(1));
        chk("t1_valid_lat", 64'(t_valid - t_start), 64'(2));
        chk("t1_done_lat",  64'(t_done - t_start),  64'(21));
        chk_full_scan("t1");
        chk("t1_word3", 64'(bus.word_out), 64'(32'hA3));

        // 2: display not ready; one read, word held, accepted once.
        mode_auto = 1'b0; ready = 1'b0; en_cnt = 0; clear_acc();
        pulse_start();
        cyc_wait(8);
        chk("t2_en_cnt", 64'(en_cnt), 64'(1));
        chk("t2_valid",  64'(bus.word_valid), 64'(1'b1));
        chk("t2_naccs",  64'(acc_addr.size()), 64'(0));
        ready = 1'b1;
        cyc_wait(5);
        chk("t2_accs", 64'(acc_addr.size()), 64'(1));
        chk("t2_word", 64'(bus.word_out), 64'(32'hA0));

        // 4: manual stepping; a step while the word is presented is ignored.
        clear_acc(); ready = 1'b0;
        pulse_step();
        cyc_wait(3);
        pulse_step();
        cyc_wait(2);
        chk("t4_valid", 64'(bus.word_valid), 64'(1'b1));
        chk("t4_aout",  64'(bus.addr_out),   64'(3'd1));
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_wait(9);
            pulse_step();
        end
        cyc_wait(3);
        chk("t4_done",  64'(done), 64'(1'b1));
        chk("t4_accs",  64'(acc_addr.size()), 64'(3));
        for (int i = 0; i < acc_addr.size() && i < 3; i++) chk("t4_addr", 64'(acc_addr[i]), 64'(i + 1));

        // 3: halt drops during the read of address 2, resumes five cycles later.
        mode_auto = 1'b1; clear_acc();
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (bus.read_mem_en && bus.read_mem_addr == 3'd2) found = 1'b1;
            else cyc_wait(1);
        end
        chk("t3_found", 64'(found), 64'(1'b1));
        d = cyc;
        cpu_halted = 1'b0;
        cyc_wait(5);
        cpu_halted = 1'b1;
        for (int n = 0; n < 20 && !bus.read_mem_en; n++) @(negedge clk);
        chk("t3_resume_cyc",  64'(cyc), 64'(d + 6));
        chk("t3_resume_addr", 64'(bus.read_mem_addr), 64'(3'd2));
        wait_done(60);
        chk_full_scan("t3");

        // 5: start while busy is ignored; start in done clears done.
        clear_acc();
        pulse_start();
        chk("t5_done_clr", 64'(done), 64'(1'b0));
        chk("t5_busy",     64'(busy), 64'(1'b1));
        cyc_wait(6);
        pulse_start();
        wait_done(60);
        chk_full_scan("t5");

        // 6: asynchronous reset in the middle of a read.
        pulse_start();
        for (int n = 0; n < 20 && !bus.read_mem_en; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_en_async",    64'(bus.read_mem_en), 64'(1'b0));
        chk("t6_busy_async",  64'(busy),            64'(1'b0));
        chk("t6_aout_async",  64'(bus.addr_out),    64'(3'd0));
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(2);
        chk("t6_idle_busy", 64'(busy), 64'(1'b0));
        chk("t6_idle_done", 64'(done), 64'(1'b0));

        // Random phase: everything checked by the per-cycle model.
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            cpu_halted = ($urandom % 8) != 0;
            ready      = ($urandom % 3) != 0;
            step       = ($urandom % 6) == 0;
            start      = ($urandom % 20) == 0;
            mode_auto  = ($urandom % 4) != 0;
            rst_n      = ($urandom % 400) != 0;
            cyc_wait(1);
        end
        rst_n = 1'b1;
        cyc_wait(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
